// File: rtl/event_dispatch_ctrl.sv
// Event dispatcher: buffers CAVIAR events and hands them one at a time to the activation
// engine, and sweeps the timestamp memory to zero when a clear is requested.

module event_dispatch_ctrl #(
    parameter int DVS_WIDTH       = 346,
    parameter int DVS_HEIGHT      = 260,
    parameter int CAVIAR_X_Y_BITS = 9,
    parameter int TIMESTAMP_BITS  = 16,
    parameter int WORD_SIZE       = 18,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [2*CAVIAR_X_Y_BITS:0]        ev_in,
    input  logic [TIMESTAMP_BITS-1:0]         ev_ts,
    input  logic                              ev_vld,
    output logic                              ev_rdy,
    input  logic                              clear_req,
    output logic                              clear_busy,
    output logic [2*CAVIAR_X_Y_BITS:0]        cavier_out,
    output logic [TIMESTAMP_BITS-1:0]         ts_out,
    output logic                              dispatch_vld,
    input  logic                              engine_done,
    output logic                              mem_sel,
    output logic [CAVIAR_X_Y_BITS-1:0]        clr_addr_x,
    output logic [CAVIAR_X_Y_BITS-1:0]        clr_addr_y,
    output logic [WORD_SIZE-1:0]              clr_wdata,
    output logic                              clr_rw,
    output logic                              clr_cen,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic [15:0]                       drop_cnt,
    output logic                              timeout_err
);

    localparam int EV_W  = 2*CAVIAR_X_Y_BITS + 1;
    localparam int ENT_W = EV_W + TIMESTAMP_BITS;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PTR_W-1:0]           PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0]           LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0]           TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CAVIAR_X_Y_BITS-1:0] X_LAST   = CAVIAR_X_Y_BITS'(DVS_WIDTH - 1);
    localparam logic [CAVIAR_X_Y_BITS-1:0] Y_LAST   = CAVIAR_X_Y_BITS'(DVS_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISPATCH  = 2'd1,
        WAIT_DONE = 2'd2,
        CLEAR     = 2'd3
    } state_t;

    state_t                     state_r;
    state_t                     state_next_s;
    logic [ENT_W-1:0]           fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [LVL_W-1:0]           level_r;
    logic [15:0]                drop_r;
    logic                       pending_r;
    logic                       timeout_r;
    logic [TMR_W-1:0]           timer_r;
    logic [CAVIAR_X_Y_BITS-1:0] x_r;
    logic [CAVIAR_X_Y_BITS-1:0] y_r;
    logic [EV_W-1:0]            ev_out_r;
    logic [TIMESTAMP_BITS-1:0]  ts_out_r;
    logic                       ev_rdy_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       timer_last_s;
    logic                       sweep_last_s;
    logic                       go_dispatch_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? {PTR_W{1'b0}} : ptr + 1'b1;
    endfunction

    assign ev_rdy_s      = (level_r != LVL_FULL);
    assign push_s        = ev_vld & ev_rdy_s;
    assign pop_s         = (state_r == DISPATCH);
    assign timer_last_s  = (timer_r == TMR_LAST);
    assign sweep_last_s  = (x_r == X_LAST) && (y_r == Y_LAST);
    assign go_dispatch_s = (state_r == IDLE) && (state_next_s == DISPATCH);

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decision; a pending clear takes priority over buffered events
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pending_r) begin
                    state_next_s = CLEAR;
                end else if (level_r != {LVL_W{1'b0}}) begin
                    state_next_s = DISPATCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DISPATCH:  state_next_s = WAIT_DONE;
            WAIT_DONE: begin
                if (engine_done || timer_last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            CLEAR: begin
                if (sweep_last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Event buffer storage, pointers, fill level and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {ENT_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            drop_r   <= 16'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {ev_in, ev_ts};
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
            if (ev_vld && !ev_rdy_s && (drop_r != 16'hFFFF)) begin
                drop_r <= drop_r + 16'd1;
            end
        end
    end

    // Dispatch payload, engine watchdog, clear bookkeeping and sweep address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_out_r  <= {EV_W{1'b0}};
            ts_out_r  <= {TIMESTAMP_BITS{1'b0}};
            timer_r   <= {TMR_W{1'b0}};
            timeout_r <= 1'b0;
            pending_r <= 1'b0;
            x_r       <= {CAVIAR_X_Y_BITS{1'b0}};
            y_r       <= {CAVIAR_X_Y_BITS{1'b0}};
        end else begin
            if (go_dispatch_s) begin
                {ev_out_r, ts_out_r} <= fifo_mem_r[rd_ptr_r];
            end
            timer_r <= (state_r == WAIT_DONE) ? timer_r + 1'b1 : {TMR_W{1'b0}};
            if ((state_r == WAIT_DONE) && !engine_done && timer_last_s) begin
                timeout_r <= 1'b1;
            end
            // Requests arriving while the sweep runs are dropped rather than queued
            if ((state_r == CLEAR) && sweep_last_s) begin
                pending_r <= 1'b0;
            end else if (clear_req && (state_r != CLEAR)) begin
                pending_r <= 1'b1;
            end
            if ((state_r == CLEAR) && !sweep_last_s) begin
                if (x_r == X_LAST) begin
                    x_r <= {CAVIAR_X_Y_BITS{1'b0}};
                    y_r <= y_r + 1'b1;
                end else begin
                    x_r <= x_r + 1'b1;
                end
            end else begin
                x_r <= {CAVIAR_X_Y_BITS{1'b0}};
                y_r <= {CAVIAR_X_Y_BITS{1'b0}};
            end
        end
    end

    assign ev_rdy       = ev_rdy_s;
    assign clear_busy   = pending_r | (state_r == CLEAR);
    assign cavier_out   = ev_out_r;
    assign ts_out       = ts_out_r;
    assign dispatch_vld = (state_r == DISPATCH);
    assign mem_sel      = (state_r == CLEAR);
    assign clr_cen      = (state_r == CLEAR);
    assign clr_rw       = (state_r == CLEAR);
    assign clr_addr_x   = x_r;
    assign clr_addr_y   = y_r;
    assign clr_wdata    = {WORD_SIZE{1'b0}};
    assign fifo_level   = level_r;
    assign drop_cnt     = drop_r;
    assign timeout_err  = timeout_r;

endmodule
